// File: rtl/i2c_master_byte_pkg.sv
// Shared I2C definitions: command codes, acknowledge levels and the
// byte-level controller state encoding.
package i2c_master_byte_pkg;

   localparam logic [2:0] CMD_START = 3'd0;
   localparam logic [2:0] CMD_WRITE = 3'd1;
   localparam logic [2:0] CMD_READ  = 3'd2;
   localparam logic [2:0] CMD_STOP  = 3'd3;

   localparam logic I2C_ACK = 1'b0;
   localparam logic I2C_NAK = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_WRITE,
      ST_READ,
      ST_ACK,
      ST_STOP
   } state_t;

endpackage

// File: rtl/i2c_master_byte_tick_gen.sv
// Quarter-bit tick generator: down-counter that reloads on load, freezes on
// stall and pulses tick on its terminal count.
module i2c_tick_gen #(
   parameter int unsigned CLK_DIV = 125
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic stall,
   output logic tick
);

   localparam logic [15:0] RELOAD = 16'(CLK_DIV - 1);

   logic [15:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      tick  = 1'b0;
      if (load) begin
         cnt_d = RELOAD;
      end else if (!stall) begin
         if (cnt_q == 16'd0) begin
            tick  = 1'b1;
            cnt_d = RELOAD;
         end else begin
            cnt_d = cnt_q - 16'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: rtl/i2c_master_byte.sv
// Byte-level I2C master: executes one START/WRITE/READ/STOP command at a time,
// four ticks per bit, with clock stretching and arbitration-loss detection.
module i2c_master_byte
   import i2c_master_byte_pkg::*;
#(
   parameter int unsigned CLK_DIV = 125
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmdValid,
   output logic       cmdReady,
   input  logic [2:0] cmd,
   input  logic [7:0] txData,
   input  logic       rdNak,
   output logic       doneValid,
   output logic [7:0] rxData,
   output logic       ackRcvd,
   output logic       arbLost,
   output logic       busy,
   output logic       sclOut,
   output logic       sdaOut,
   input  logic       sclIn,
   input  logic       sdaIn
);

   state_t      state_q, state_d;
   logic [1:0]  phase_q, phase_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  sh_q, sh_d;
   logic [7:0]  rx_q, rx_d;
   logic        nak_q, nak_d, rd_q, rd_d;
   logic        busy_q, busy_d, done_q, done_d, arb_q, arb_d, ack_q, ack_d;
   logic        scl_hold_q, scl_hold_d, sda_hold_q, sda_hold_d;
   logic        tick, accept, last_phase, stall;

   assign accept     = cmdValid && cmdReady;
   assign last_phase = tick && (phase_q == 2'd3);
   // Counter only runs while a command owns it; a slave holding a released SCL low freezes it.
   assign stall      = (state_q == ST_IDLE) || (sclOut && !sclIn);

   i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk   (clk),
      .rst   (rst),
      .load  (accept),
      .stall (stall),
      .tick  (tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         phase_q    <= 2'd0;
         bit_cnt_q  <= 3'd0;
         sh_q       <= 8'h00;
         rx_q       <= 8'h00;
         nak_q      <= 1'b0;
         rd_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         arb_q      <= 1'b0;
         ack_q      <= 1'b1;
         scl_hold_q <= 1'b1;
         sda_hold_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         bit_cnt_q  <= bit_cnt_d;
         sh_q       <= sh_d;
         rx_q       <= rx_d;
         nak_q      <= nak_d;
         rd_q       <= rd_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         arb_q      <= arb_d;
         ack_q      <= ack_d;
         scl_hold_q <= scl_hold_d;
         sda_hold_q <= sda_hold_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      bit_cnt_d  = bit_cnt_q;
      sh_d       = sh_q;
      rx_d       = rx_q;
      nak_d      = nak_q;
      rd_d       = rd_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      arb_d      = 1'b0;
      ack_d      = ack_q;
      scl_hold_d = scl_hold_q;
      sda_hold_d = sda_hold_q;
      if (tick) phase_d = phase_q + 2'd1;
      case (state_q)
         ST_IDLE: if (accept) begin
            sh_d      = txData;
            nak_d     = rdNak;
            rd_d      = (cmd == CMD_READ);
            phase_d   = 2'd0;
            bit_cnt_d = 3'd0;
            if (cmd == CMD_START) begin
               state_d = ST_START;
            end else if (!busy_q) begin
               done_d = 1'b1;
               arb_d  = 1'b1;
            end else begin
               case (cmd)
                  CMD_WRITE: state_d = ST_WRITE;
                  CMD_READ:  state_d = ST_READ;
                  CMD_STOP:  state_d = ST_STOP;
                  default:   done_d  = 1'b1;
               endcase
            end
         end
         ST_START: if (last_phase) begin
            state_d    = ST_IDLE;
            busy_d     = 1'b1;
            done_d     = 1'b1;
            scl_hold_d = 1'b0;
            sda_hold_d = 1'b0;
         end
         ST_WRITE: if (last_phase) begin
            if (sh_q[7] && !sdaIn) begin
               state_d    = ST_IDLE;
               arb_d      = 1'b1;
               busy_d     = 1'b0;
               scl_hold_d = 1'b1;
               sda_hold_d = 1'b1;
            end else begin
               sh_d      = {sh_q[6:0], 1'b0};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = ST_ACK;
            end
         end
         ST_READ: if (last_phase) begin
            rx_d      = {rx_q[6:0], sdaIn};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = ST_ACK;
         end
         ST_ACK: if (last_phase) begin
            state_d = ST_IDLE;
            if (rd_q && nak_q && !sdaIn) begin
               arb_d      = 1'b1;
               busy_d     = 1'b0;
               scl_hold_d = 1'b1;
               sda_hold_d = 1'b1;
            end else begin
               if (!rd_q) ack_d = sdaIn;
               done_d     = 1'b1;
               scl_hold_d = 1'b0;
               sda_hold_d = 1'b1;
            end
         end
         ST_STOP: if (last_phase) begin
            state_d    = ST_IDLE;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            scl_hold_d = 1'b1;
            sda_hold_d = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Between commands the lines keep the level the last command left them at.
   always_comb begin
      sclOut = scl_hold_q;
      sdaOut = sda_hold_q;
      case (state_q)
         ST_START: case (phase_q)
            2'd0:    sdaOut = 1'b1;
            2'd1:    begin sclOut = 1'b1; sdaOut = 1'b1; end
            2'd2:    begin sclOut = 1'b1; sdaOut = 1'b0; end
            default: begin sclOut = 1'b0; sdaOut = 1'b0; end
         endcase
         ST_WRITE: begin sclOut = phase_q[1]; sdaOut = sh_q[7]; end
         ST_READ:  begin sclOut = phase_q[1]; sdaOut = 1'b1; end
         ST_ACK:   begin sclOut = phase_q[1]; sdaOut = rd_q ? nak_q : 1'b1; end
         ST_STOP: case (phase_q)
            2'd0:    sdaOut = 1'b0;
            2'd1:    begin sclOut = 1'b1; sdaOut = 1'b0; end
            default: begin sclOut = 1'b1; sdaOut = 1'b1; end
         endcase
         default: ;
      endcase
   end

   assign cmdReady  = (state_q == ST_IDLE) && !done_q && !arb_q;
   assign doneValid = done_q;
   assign arbLost   = arb_q;
   assign busy      = busy_q;
   assign ackRcvd   = ack_q;
   assign rxData    = rx_q;

endmodule

// File: tb/tb_i2c_master_byte.sv
// Bench for i2c_master_byte: a bit-level waveform model builds the expected
// per-cycle bus/handshake trace of each command and drives the slave side.
module tb_i2c_master_byte;
   import i2c_master_byte_pkg::*;

   localparam int DIV = 4;

   logic       clk, rst, cmdValid, cmdReady, rdNak, doneValid, ackRcvd, arbLost, busy;
   logic       sclOut, sdaOut, sclIn, sdaIn;
   logic [2:0] cmd;
   logic [7:0] txData, rxData;
   logic       slv_sda, slv_scl;

   assign sdaIn = sdaOut & slv_sda;
   assign sclIn = sclOut & ~slv_scl;

   i2c_master_byte #(.CLK_DIV(DIV)) dut (
      .clk(clk), .rst(rst), .cmdValid(cmdValid), .cmdReady(cmdReady), .cmd(cmd),
      .txData(txData), .rdNak(rdNak), .doneValid(doneValid), .rxData(rxData),
      .ackRcvd(ackRcvd), .arbLost(arbLost), .busy(busy), .sclOut(sclOut),
      .sdaOut(sdaOut), .sclIn(sclIn), .sdaIn(sdaIn)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_chk++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
      end
   endfunction

   // expected trace: one entry per clock cycle after command acceptance
   typedef struct packed {
      logic scl, sda, done, arb, busy, ready, ssda, sscl;
   } ent_t;
   ent_t exp_q[$];

   logic m_scl = 1'b1, m_sda = 1'b1, m_busy = 1'b0;

   task automatic push_e(input logic scl, input logic sda, input logic done, input logic arb,
                         input logic bsy, input logic rdy, input logic ssda, input logic sscl);
      ent_t e;
      e = '{scl: scl, sda: sda, done: done, arb: arb, busy: bsy, ready: rdy, ssda: ssda, sscl: sscl};
      exp_q.push_back(e);
   endtask

   // one data/ack bit: SCL low for the first half, high for the second
   task automatic push_bit(input logic sda, input logic ssda, input int stretch);
      for (int c = 0; c < 4*DIV; c++) begin
         if (stretch > 0 && c == 2*DIV + 1)
            for (int s = 0; s < stretch; s++) push_e(1'b1, sda, 1'b0, 1'b0, m_busy, 1'b0, ssda, 1'b1);
         push_e(c >= 2*DIV, sda, 1'b0, 1'b0, m_busy, 1'b0, ssda, 1'b0);
      end
   endtask

   task automatic m_start();
      logic b0 = m_busy;
      for (int c = 0; c < 4*DIV; c++) begin
         case (c / DIV)
            0:       push_e(m_scl, 1'b1, 1'b0, 1'b0, b0, 1'b0, 1'b1, 1'b0);
            1:       push_e(1'b1,  1'b1, 1'b0, 1'b0, b0, 1'b0, 1'b1, 1'b0);
            2:       push_e(1'b1,  1'b0, 1'b0, 1'b0, b0, 1'b0, 1'b1, 1'b0);
            default: push_e(1'b0,  1'b0, 1'b0, 1'b0, b0, 1'b0, 1'b1, 1'b0);
         endcase
      end
      push_e(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      push_e(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      m_scl = 1'b0; m_sda = 1'b0; m_busy = 1'b1;
   endtask

   task automatic m_stop();
      for (int c = 0; c < 4*DIV; c++) begin
         case (c / DIV)
            0:       push_e(m_scl, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            1:       push_e(1'b1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            default: push_e(1'b1,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
         endcase
      end
      push_e(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      push_e(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      m_scl = 1'b1; m_sda = 1'b1; m_busy = 1'b0;
   endtask

   task automatic m_write(input logic [7:0] d, input logic sack, input int sbit, input int abit);
      for (int i = 0; i < 8; i++) begin
         logic b = d[7-i];
         logic s = (i == abit) ? 1'b0 : 1'b1;
         push_bit(b, s, (i == sbit) ? 20 : 0);
         if (b && !s) begin
            push_e(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            push_e(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            m_scl = 1'b1; m_sda = 1'b1; m_busy = 1'b0;
            return;
         end
      end
      push_bit(1'b1, sack, 0);
      push_e(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      push_e(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      m_scl = 1'b0; m_sda = 1'b1;
   endtask

   task automatic m_read(input logic [7:0] sbyte, input logic nak);
      for (int i = 0; i < 8; i++) push_bit(1'b1, sbyte[7-i], 0);
      push_bit(nak, 1'b1, 0);
      push_e(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      push_e(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      m_scl = 1'b0; m_sda = 1'b1;
   endtask

   task automatic model_cmd(input logic [2:0] c, input logic [7:0] d, input logic nak, input logic sack,
                            input logic [7:0] sbyte, input int sbit, input int abit);
      if (c == CMD_START) m_start();
      else if (!m_busy) begin
         push_e(m_scl, m_sda, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
         push_e(m_scl, m_sda, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      end else if (c == CMD_WRITE) m_write(d, sack, sbit, abit);
      else if (c == CMD_READ) m_read(sbyte, nak);
      else m_stop();
   endtask

   // compare process, also plays the slave side from the trace
   always @(negedge clk) begin
      ent_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("trace_scl",   sclOut,    e.scl);
         chk("trace_sda",   sdaOut,    e.sda);
         chk("trace_done",  doneValid, e.done);
         chk("trace_arb",   arbLost,   e.arb);
         chk("trace_busy",  busy,      e.busy);
         chk("trace_ready", cmdReady,  e.ready);
         slv_sda = e.ssda;
         slv_scl = e.sscl;
      end else begin
         slv_sda = 1'b1;
         slv_scl = 1'b0;
      end
   end

   // bus monitor: start conditions, bits seen at SCL rising, pulse counts
   int         start_cnt = 0, done_cnt = 0, arb_cnt = 0, mon_cnt = 0;
   logic [8:0] mon9 = '0;
   logic       p_scl = 1'b1, p_sda = 1'b1;
   always @(negedge clk) begin
      if (p_scl && sclIn && p_sda && !sdaIn) start_cnt++;
      if (!p_scl && sclIn) begin mon9 = {mon9[7:0], sdaIn}; mon_cnt++; end
      if (doneValid) done_cnt++;
      if (arbLost) arb_cnt++;
      p_scl = sclIn;
      p_sda = sdaIn;
   end

   time        acc_t;
   int         lat;
   logic       ack_at_done;
   logic [7:0] rx_at_done;

   task automatic run_cmd(input logic [2:0] c, input logic [7:0] d, input logic nak, input logic sack,
                          input logic [7:0] sbyte, input int sbit, input int abit);
      logic imm, got;
      int   n, k;
      @(negedge clk);
      chk("ready_before_cmd", cmdReady, 1'b1);
      cmdValid = 1'b1; cmd = c; txData = d; rdNak = nak;
      @(posedge clk);
      acc_t = $time;
      imm   = (c != CMD_START) && !m_busy;
      model_cmd(c, d, nak, sack, sbyte, sbit, abit);
      n = 0; got = 1'b0;
      while (n < 600 && !got) begin
         @(negedge clk);
         if (n == 0) begin
            if (imm) cmdValid = 1'b0;
            else     cmd = CMD_STOP;   // held request while not ready must be ignored
         end
         if (n == 2) cmdValid = 1'b0;
         if (doneValid || arbLost) begin
            got = 1'b1;
            ack_at_done = ackRcvd;
            rx_at_done  = rxData;
         end
         n++;
      end
      cmdValid = 1'b0;
      if (!got) chk("completion_timeout", 32'd0, 32'd1);
      lat = int'(($time - acc_t - 64'd5) / 64'd10);
      k = 0;
      while (exp_q.size() > 0 && k < 10) begin @(negedge clk); k++; end
   endtask

   int s0, d0, a0;

   initial begin
      rst = 1'b1; cmdValid = 1'b0; cmd = CMD_START; txData = 8'h00; rdNak = 1'b0;
      #12;
      chk("rst_scl", sclOut, 1'b1);
      chk("rst_sda", sdaOut, 1'b1);
      chk("rst_ready", cmdReady, 1'b1);
      chk("rst_done", doneValid, 1'b0);
      chk("rst_arb", arbLost, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ack", ackRcvd, 1'b1);
      chk("rst_rx", rxData, 8'h00);
      @(negedge clk); rst = 1'b0;
      repeat (2) @(negedge clk);

      // STOP while bus is free: immediate done + arbLost
      d0 = done_cnt; a0 = arb_cnt;
      run_cmd(CMD_STOP, 8'h00, 1'b0, 1'b0, 8'h00, -1, -1);
      chk("idle_stop_lat", lat, 0);
      chk("idle_stop_arb_pulses", arb_cnt - a0, 1);

      // START then WRITE A0, slave ACKs
      s0 = start_cnt;
      run_cmd(CMD_START, 8'h00, 1'b0, 1'b0, 8'h00, -1, -1);
      chk("start_lat", lat, 16);
      chk("start_cond_seen", start_cnt - s0, 1);
      mon_cnt = 0;
      run_cmd(CMD_WRITE, 8'hA0, 1'b0, I2C_ACK, 8'h00, -1, -1);
      chk("write_a0_lat", lat, 144);
      chk("write_a0_ack", ack_at_done, 1'b0);
      chk("write_a0_bits", mon9, 9'h140);
      chk("write_a0_nbits", mon_cnt, 9);

      // READ 5C with NAK
      d0 = done_cnt;
      run_cmd(CMD_READ, 8'h00, I2C_NAK, 1'b0, 8'h5C, -1, -1);
      chk("read_rx", rx_at_done, 8'h5C);
      chk("read_lat", lat, 144);
      chk("read_done_pulses", done_cnt - d0, 1);

      // WRITE 3C with a 20-cycle stretch in bit 3
      run_cmd(CMD_WRITE, 8'h3C, 1'b0, I2C_ACK, 8'h00, 3, -1);
      chk("stretch_lat", lat, 164);
      chk("stretch_ack", ack_at_done, 1'b0);

      // repeated START
      s0 = start_cnt;
      run_cmd(CMD_START, 8'h00, 1'b0, 1'b0, 8'h00, -1, -1);
      chk("rstart_cond_seen", start_cnt - s0, 1);
      chk("rstart_busy", busy, 1'b1);

      // WRITE FF, another master pulls SDA on bit 2
      d0 = done_cnt; a0 = arb_cnt;
      run_cmd(CMD_WRITE, 8'hFF, 1'b0, I2C_ACK, 8'h00, -1, 2);
      chk("arb_pulses", arb_cnt - a0, 1);
      chk("arb_no_done", done_cnt - d0, 0);
      chk("arb_scl", sclOut, 1'b1);
      chk("arb_sda", sdaOut, 1'b1);
      chk("arb_lat", lat, 48);

      // WRITE on a free bus, then START / WRITE 55 with NAK / STOP
      run_cmd(CMD_WRITE, 8'h12, 1'b0, I2C_ACK, 8'h00, -1, -1);
      chk("idle_write_lat", lat, 0);
      run_cmd(CMD_START, 8'h00, 1'b0, 1'b0, 8'h00, -1, -1);
      run_cmd(CMD_WRITE, 8'h55, 1'b0, I2C_NAK, 8'h00, -1, -1);
      chk("write_55_nak", ack_at_done, 1'b1);
      run_cmd(CMD_STOP, 8'h00, 1'b0, 1'b0, 8'h00, -1, -1);
      chk("stop_lat", lat, 16);
      chk("stop_busy", busy, 1'b0);

      // reset in the middle of a READ
      run_cmd(CMD_START, 8'h00, 1'b0, 1'b0, 8'h00, -1, -1);
      @(negedge clk);
      cmdValid = 1'b1; cmd = CMD_READ; rdNak = 1'b0;
      @(posedge clk);
      model_cmd(CMD_READ, 8'h00, 1'b0, 1'b0, 8'hC3, -1, -1);
      @(negedge clk); cmdValid = 1'b0;
      repeat (50) @(negedge clk);
      #1;
      exp_q.delete();
      rst = 1'b1;
      #1;
      chk("midrst_scl", sclOut, 1'b1);
      chk("midrst_sda", sdaOut, 1'b1);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      m_scl = 1'b1; m_sda = 1'b1; m_busy = 1'b0;
      @(negedge clk);
      chk("midrst_ready", cmdReady, 1'b1);
      chk("midrst_busy", busy, 1'b0);
      run_cmd(CMD_STOP, 8'h00, 1'b0, 1'b0, 8'h00, -1, -1);
      chk("post_rst_stop_lat", lat, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
      $fatal(1, "watchdog");
   end

endmodule
